// File: rtl/cnna_mac_pkg.sv
// Shared types and helpers for the CNN accelerator multiply/accumulate pipeline.
package cnna_mac_pkg;

    localparam int CNNA_MAC_MAX_STAGE = 8;
    localparam int CNNA_MAC_MAX_OPW   = 32;

    typedef struct packed {
        logic valid;
        logic last;
        logic accEn;
        logic accFirst;
    } cnna_mac_side_t;

    // Extends the low 'width' bits of val by at least one bit, sign- or zero-filled.
    function automatic logic [CNNA_MAC_MAX_OPW:0] cnna_mac_ext(
        input logic [CNNA_MAC_MAX_OPW-1:0] val,
        input int                          width,
        input logic                        sgn
    );
        logic [CNNA_MAC_MAX_OPW:0] r;
        logic                      fill;
        fill = 1'b0;
        for (int i = 0; i < CNNA_MAC_MAX_OPW; i++) begin
            if (i == width - 1) fill = sgn & val[i];
        end
        for (int i = 0; i < CNNA_MAC_MAX_OPW; i++) begin
            r[i] = (i < width) ? val[i] : fill;
        end
        r[CNNA_MAC_MAX_OPW] = fill;
        return r;
    endfunction

endpackage

// File: rtl/cnna_mac_pipe_if.sv
// Operand/result bundle between the fetch stage, the MAC pipe and the requantiser.
interface cnna_mac_pipe_if #(
    parameter int DIN0_WIDTH = 10,
    parameter int DIN1_WIDTH = 9,
    parameter int DOUT_WIDTH = 19
);
    logic                  ce;
    logic                  in_valid;
    logic [DIN0_WIDTH-1:0] din0;
    logic [DIN1_WIDTH-1:0] din1;
    logic                  din0_sgn;
    logic                  din1_sgn;
    logic                  acc_en;
    logic                  acc_first;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_last;
    logic [DOUT_WIDTH-1:0] dout;

    modport master (
        output ce, in_valid, din0, din1, din0_sgn, din1_sgn, acc_en, acc_first, in_last,
        input  out_valid, out_last, dout
    );

    modport slave (
        input  ce, in_valid, din0, din1, din0_sgn, din1_sgn, acc_en, acc_first, in_last,
        output out_valid, out_last, dout
    );
endinterface

// File: rtl/cnna_mac_delay_line.sv
// Clock-enabled shift register; only the valid bits are reset, payload is reset-less.
import cnna_mac_pkg::*;

module cnna_mac_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unusedCtl;
            assign unusedCtl = ^{clk, rst_n, ce_i};
            assign valid_o   = valid_i;
            assign data_o    = data_i;
        end else begin : g_shift
            logic [DEPTH-1:0] valid_q;
            logic [WIDTH-1:0] data_q [DEPTH];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    valid_q <= '0;
                end else if (ce_i) begin
                    valid_q[0] <= valid_i;
                    for (int i = 1; i < DEPTH; i++) valid_q[i] <= valid_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (ce_i) begin
                    data_q[0] <= data_i;
                    for (int i = 1; i < DEPTH; i++) data_q[i] <= data_q[i-1];
                end
            end

            assign valid_o = valid_q[DEPTH-1];
            assign data_o  = data_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/cnna_mac_pipe.sv
// Pipelined signed/unsigned multiplier with an optional running accumulator in the last stage.
import cnna_mac_pkg::*;

module cnna_mac_pipe #(
    parameter int DIN0_WIDTH = 10,
    parameter int DIN1_WIDTH = 9,
    parameter int DOUT_WIDTH = 19,
    parameter int NUM_STAGE  = 3
) (
    input  logic ap_clk,
    input  logic ap_rst_n,
    cnna_mac_pipe_if.slave bus
);

    localparam int ProdW    = DIN0_WIDTH + DIN1_WIDTH + 2;
    localparam int StageCnt = (NUM_STAGE < 1) ? 1 :
                              (NUM_STAGE > CNNA_MAC_MAX_STAGE) ? CNNA_MAC_MAX_STAGE : NUM_STAGE;
    localparam int DataW    = DOUT_WIDTH + 3;

    logic [CNNA_MAC_MAX_OPW:0]   ext0Full;
    logic [CNNA_MAC_MAX_OPW:0]   ext1Full;
    logic signed [DIN0_WIDTH:0]  opA;
    logic signed [DIN1_WIDTH:0]  opB;
    logic signed [ProdW-1:0]     prodFull;
    logic                        prodExtSgn;
    logic [DOUT_WIDTH-1:0]       prodRes;
    logic                        unusedExtBits;

    assign ext0Full      = cnna_mac_ext(CNNA_MAC_MAX_OPW'(bus.din0), DIN0_WIDTH, bus.din0_sgn);
    assign ext1Full      = cnna_mac_ext(CNNA_MAC_MAX_OPW'(bus.din1), DIN1_WIDTH, bus.din1_sgn);
    assign opA           = ext0Full[DIN0_WIDTH:0];
    assign opB           = ext1Full[DIN1_WIDTH:0];
    assign unusedExtBits = ^{ext0Full[CNNA_MAC_MAX_OPW:DIN0_WIDTH+1],
                             ext1Full[CNNA_MAC_MAX_OPW:DIN1_WIDTH+1]};

    // Both operands carry a guard bit, so one signed multiply covers all four mode combinations.
    assign prodFull   = ProdW'(opA) * ProdW'(opB);
    assign prodExtSgn = bus.din0_sgn | bus.din1_sgn;

    generate
        if (DOUT_WIDTH < ProdW) begin : g_trunc
            logic unusedProd;
            assign unusedProd = ^{prodExtSgn, prodFull[ProdW-1:DOUT_WIDTH]};
            assign prodRes    = prodFull[DOUT_WIDTH-1:0];
        end else if (DOUT_WIDTH == ProdW) begin : g_exact
            logic unusedSgn;
            assign unusedSgn = prodExtSgn;
            assign prodRes   = prodFull;
        end else begin : g_extend
            assign prodRes = {{(DOUT_WIDTH-ProdW){prodExtSgn & prodFull[ProdW-1]}}, prodFull};
        end
    endgenerate

    cnna_mac_side_t        sideIn;
    cnna_mac_side_t        sideOut;
    logic [DOUT_WIDTH-1:0] prodDly;

    assign sideIn.valid    = bus.in_valid;
    assign sideIn.last     = bus.in_last;
    assign sideIn.accEn    = bus.acc_en;
    assign sideIn.accFirst = bus.acc_first;

    // Every stage but the accumulator lives here; with a single stage the product feeds the accumulator directly.
    cnna_mac_delay_line #(
        .WIDTH (DataW),
        .DEPTH (StageCnt - 1)
    ) u_retime (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .ce_i    (bus.ce),
        .valid_i (sideIn.valid),
        .data_i  ({prodRes, sideIn.last, sideIn.accEn, sideIn.accFirst}),
        .valid_o (sideOut.valid),
        .data_o  ({prodDly, sideOut.last, sideOut.accEn, sideOut.accFirst})
    );

    logic [DOUT_WIDTH-1:0] acc_q, acc_d;
    logic                  outValid_q, outValid_d;
    logic                  outLast_q, outLast_d;

    always_comb begin
        acc_d      = acc_q;
        outValid_d = outValid_q;
        outLast_d  = outLast_q;
        if (bus.ce) begin
            outValid_d = sideOut.valid;
            outLast_d  = sideOut.valid & sideOut.last;
            if (sideOut.valid) begin
                acc_d = (sideOut.accEn && !sideOut.accFirst) ? acc_q + prodDly : prodDly;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            acc_q      <= '0;
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            outValid_q <= outValid_d;
            outLast_q  <= outLast_d;
        end
    end

    assign bus.dout      = acc_q;
    assign bus.out_valid = outValid_q;
    assign bus.out_last  = outLast_q;

endmodule
